// File: rtl/count_disp_pkg.sv
// Shared types and constants for the count-to-BCD display block.
// Holds the converter FSM states, the shift-cycle count, the add-3
// helper and the active-high seven-segment codes {g,f,e,d,c,b,a}.
package count_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // One shift per input bit of the 8-bit binary value.
  localparam int CONV_CYCLES = 8;

  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;

  // Double-dabble correction: a nibble >= 5 would overflow past 9 on the
  // next left shift, so pre-add 3 to carry into the next decade instead.
  function automatic logic [3:0] add3_ge5(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-high seven-segment decoder.
// Ports: digit_i (0-9, other codes dark), blank_i (force all segments off),
//        seg_o {g,f,e,d,c,b,a}, active-high; polarity is applied by the caller.
module bcd_to_seg
  import count_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/count_bcd_display.sv
// Converts the upstream 8-bit count to three BCD digits with an iterative
// double-dabble engine (sample -> 8 shifts -> publish, valid pulse on E9) and
// scans them onto a 3-digit multiplexed seven-segment display.
// Ports: clk/rst (sync, active-high); count in; bcd_hund/tens/ones, valid,
//        busy out; seg {g,f,e,d,c,b,a} and an {hund,tens,ones}, polarity per SEG_ACTIVE_LOW.
module count_bcd_display
  import count_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       valid,
  output logic       busy,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SEG_DARK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_DARK  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;

  // ---------------- converter ----------------
  state_e      state_q, state_d;
  logic [19:0] shreg_q, shreg_d;   // {hund, tens, ones, bin}
  logic [7:0]  last_val_q, last_val_d;
  logic        force_q, force_d;
  logic [2:0]  iter_q, iter_d;
  logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic [19:0] adj;

  assign adj = {add3_ge5(shreg_q[19:16]), add3_ge5(shreg_q[15:12]),
                add3_ge5(shreg_q[11:8]), shreg_q[7:0]};

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    last_val_d = last_val_q;
    force_d    = force_q;
    iter_d     = iter_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (force_q || (count != last_val_q)) begin
          shreg_d    = {12'd0, count};
          last_val_d = count;
          force_d    = 1'b0;
          iter_d     = 3'd0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        shreg_d = {adj[18:0], 1'b0};
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'(CONV_CYCLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        hund_d  = shreg_q[19:16];
        tens_d  = shreg_q[15:12];
        ones_d  = shreg_q[11:8];
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      last_val_q <= '0;
      force_q    <= 1'b1;
      iter_q     <= '0;
      hund_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      last_val_q <= last_val_d;
      force_q    <= force_d;
      iter_q     <= iter_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bcd_hund = hund_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

  // ---------------- display scan ----------------
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    scan_q, scan_d;     // 0 = ones, 1 = tens, 2 = hund
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic [3:0]    dig_sel;
  logic          blank_sel;
  logic [2:0]    an_ah;
  logic [6:0]    seg_ah;

  always_comb begin
    presc_d = presc_q + PW'(1);
    scan_d  = scan_q;
    if (presc_q == PW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      scan_d  = (scan_q == 2'd2) ? 2'd0 : scan_q + 2'd1;
    end
  end

  // Leading-zero blanking reads the published digits, so a digit only goes
  // dark once every more-significant digit is also zero.
  always_comb begin
    dig_sel   = ones_q;
    blank_sel = 1'b0;
    an_ah     = 3'b001;
    case (scan_q)
      2'd1: begin
        dig_sel   = tens_q;
        blank_sel = BLANK_LEADING && (hund_q == 4'd0) && (tens_q == 4'd0);
        an_ah     = 3'b010;
      end
      2'd2: begin
        dig_sel   = hund_q;
        blank_sel = BLANK_LEADING && (hund_q == 4'd0);
        an_ah     = 3'b100;
      end
      default: ;
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .digit_i (dig_sel),
    .blank_i (blank_sel),
    .seg_o   (seg_ah)
  );

  assign seg_d = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
  assign an_d  = SEG_ACTIVE_LOW ? ~an_ah  : an_ah;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      seg_q   <= SEG_DARK;
      an_q    <= AN_DARK;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: doc/count_bcd_display.md
Name: count_bcd_display

Overview:
Downstream consumer of the mod-47 up counter's 8-bit count output. It converts the count to three BCD digits using an iterative shift-add-3 (double-dabble) engine, and exposes the digits with a one-cycle valid strobe. It also drives a time-multiplexed 3-digit seven-segment display with optional leading-zero blanking. Sits between the counter and the board display pins.

Parameters:
REFRESH_DIV, 4, clocks per digit slot in display scan (>=1; small default for simulation)
SEG_ACTIVE_LOW, 1, 1 = seg and an outputs active-low; 0 = active-high
BLANK_LEADING, 1, 1 = blank leading zero digits (ones digit never blanked)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
count  input  8  binary value from upstream counter, sampled every clk
bcd_hund  output  4  hundreds digit of last converted value
bcd_tens  output  4  tens digit
bcd_ones  output  4  ones digit
valid  output  1  one-cycle pulse when bcd_* update
busy  output  1  high while conversion in progress
seg  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
an  output  3  digit enables, one-hot {hund,tens,ones}, polarity per SEG_ACTIVE_LOW

Behaviour:
- One clock; reset synchronous, active-high; names clk / rst.
- Reset values:
  - State IDLE; bcd_* = 0; valid = 0; busy = 0.
  - last_val = 0; force = 1.
  - Scan index = 0 (ones); prescaler = 0.
  - seg = all segments off; an = all digits off (both in configured polarity).
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - If force == 1 or count != last_val, then on this edge: capture count into the shift register and last_val, clear force, set iter = 0, go to CONV, busy <= 1.
  - Otherwise remain in IDLE.
- CONV (8 cycles):
  - Each edge: every BCD nibble >= 5 gets +3, then the 20-bit {hund,tens,ones,bin} register shifts left by 1; iter increments.
  - On the edge where iter == 7, go to DONE.
- DONE:
  - Copy nibbles to bcd_*; pulse valid = 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency and input handling:
  - Sampling edge E0 -> 8 shift edges -> bcd_* / valid update on edge E9.
  - Next sample is possible at E10.
  - count changes during CONV/DONE are ignored. On return to IDLE the current count is compared, so the latest value is always converted next; intermediate values may be skipped.
- Range: 0..255 is handled fully. Upstream only produces 0..46, so bcd_hund = 0 in normal use.
- Display scan:
  - Prescaler counts 0..REFRESH_DIV-1 continuously.
  - On wrap, scan index advances ones -> tens -> hund -> ones.
  - an and seg are registered from scan index and current bcd_* (1-cycle pipeline). Each digit is shown for REFRESH_DIV cycles.
- Blanking (BLANK_LEADING = 1):
  - hund is blanked when == 0.
  - tens is blanked when hund == 0 and tens == 0.
  - A blanked digit drives seg = all off; an stays asserted.
- Segment encoding: standard 0-9. Codes 10-15 cannot occur and drive all off.
- Reset mid-conversion: the partial result is discarded. After rst deasserts, force = 1 makes the first IDLE cycle convert the current count.
- Simultaneous prescaler wrap and valid: the display uses the new bcd_* from the following slot register update, with no glitch beyond the 1-cycle pipeline.

Decomposition:
- Shared package count_disp_pkg:
  - state enum {IDLE, CONV, DONE}
  - CONV_CYCLES = 8
  - SEG_OFF constant
  - 7-bit active-high segment constants SEG_0..SEG_9
- One sub-module: bcd_to_seg (4-bit digit + blank in -> 7-bit active-high segments, combinational). The top applies polarity.
- Expected size: ~180-250 lines RTL.

Test Plan:
- Reset, count = 0, release rst: busy high for 9 cycles, valid pulses once, bcd = 0/0/0. While the ones slot is active, seg = 7'b1000000 (active-low "0"); hund and tens are blanked (seg = 7'b1111111).
- count = 46 held: valid 9 cycles after sampling, bcd = 0/4/6. Ones slot seg = 7'b0000010, tens slot seg = 7'b0011001, hund blanked.
- count = 255: bcd = 2/5/5, no digits blanked. Exhaustive sweep 0..255 checked against a div/mod model.
- count steps 10 -> 11 -> 12 on consecutive cycles during CONV: exactly one extra conversion follows, final bcd = 0/1/2, with no intermediate valid for 11.
- Assert rst at the 4th CONV cycle for 1 clock: busy = 0, valid never pulses, bcd = 0. The next conversion of the held count completes normally.
- REFRESH_DIV = 4: an (active-low) cycles 110 -> 101 -> 011, each held exactly 4 clocks, with a period of 12 clocks.
